// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by all elastic pipeline stages.
//   state_e         occupancy-coded stage state (EMPTY/ONE/FULL)
//   DEFAULT_DATA_W  default payload width (16 instr + 16 pc + 1 taken + 10 decode)
//   NOP_DATA        bubble encoding loaded on reset and flush
//   DEFAULT_STALL_W default width of the stall cycle counter
package pipe_pkg;

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int DEFAULT_DATA_W  = 43;
  localparam int DEFAULT_STALL_W = 16;

  localparam logic [DEFAULT_DATA_W-1:0] NOP_DATA = '0;

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk  rising-edge clock
//   rst  asynchronous active-low reset (count -> 0)
//   clr  synchronous clear, wins over inc
//   inc  count enable; the count sticks at all ones
//   cnt  current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && (cnt_reg != {W{1'b1}})) begin
      cnt_next = cnt_reg + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: single-clock elastic pipeline stage with a 2-entry skid
// buffer, synchronous flush with bubble injection and a stall counter.
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous squash of all held entries
//   in_valid   upstream payload present
//   in_ready   stage can accept (registered)
//   in_data    upstream payload
//   out_valid  out_data is valid
//   out_ready  downstream accepts this cycle
//   out_data   head payload (main register)
//   occupancy  held entries, 0..2
//   cnt_clr    synchronous clear of stall_cnt
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] FLUSH_DATA = DATA_W'(NOP_DATA),
  parameter int                STALL_W    = DEFAULT_STALL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         occupancy,
  input  logic               cnt_clr,
  output logic [STALL_W-1:0] stall_cnt
);

  state_e            state_reg, state_next;
  logic [DATA_W-1:0] main_reg, main_next;
  logic [DATA_W-1:0] skid_reg, skid_next;
  logic              in_ready_reg, in_ready_next;

  logic accept;
  logic issue;

  assign accept = in_valid & in_ready_reg;
  assign issue  = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      // Flush wins: any accept this cycle is dropped; an issue this cycle has
      // already been seen by downstream, so nothing needs undoing.
      state_next = EMPTY;
      main_next  = FLUSH_DATA;
      skid_next  = FLUSH_DATA;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            main_next  = in_data;
          end
        end
        ONE: begin
          if (accept && issue) begin
            main_next = in_data;
          end else if (accept) begin
            state_next = FULL;
            skid_next  = in_data;
          end else if (issue) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only an issue can move the state.
          if (issue) begin
            state_next = ONE;
            main_next  = skid_reg;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  // Registering in_ready off the next state keeps the upstream ready path
  // free of any combinational dependence on out_ready.
  assign in_ready_next = (state_next != FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= EMPTY;
      main_reg     <= FLUSH_DATA;
      skid_reg     <= FLUSH_DATA;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      main_reg     <= main_next;
      skid_reg     <= skid_next;
      in_ready_reg <= in_ready_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_reg;
  assign occupancy = state_reg;

  sat_counter #(
    .W (STALL_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: scoreboard bench for pipe_stage_elastic.
// The stimulus side pushes every accepted payload into a queue; an
// independent monitor compares the stage against that queue (occupancy,
// ready/valid, head data, stall count) on every falling edge.
module tb_pipe_stage_elastic;

  localparam int            DW = 43;
  localparam int            SW = 4;
  localparam logic [DW-1:0] FD = 43'h123_4567_89AB;
  localparam int            SAT = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic          cnt_clr = 1'b0;
  logic [SW-1:0] stall_cnt;

  logic [DW-1:0] sb[$];
  int            stall_exp = 0;
  int            checks = 0;
  int            errors = 0;

  pipe_stage_elastic #(
    .DATA_W     (DW),
    .FLUSH_DATA (FD),
    .STALL_W    (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // Monitor: the queue is the reference; its size is the occupancy.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      stall_exp = 0;
    end else begin
      chk("occupancy", 64'(occupancy), 64'(sb.size()));
      chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(sb.size() > 0));
      chk("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
      if (cnt_clr) stall_exp = 0;
      else if (sb.size() > 0 && !out_ready && stall_exp < SAT) stall_exp++;
      if (sb.size() > 0 && out_ready) begin
        chk("out_data", 64'(out_data), 64'(sb[0]));
        $display("[%0t] issue data=%h", $time, out_data);
        void'(sb.pop_front());
      end
      if (flush) sb.delete();
    end
  end

  // One cycle of stimulus; entered and left at posedge+1.
  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy,
                       input logic fl, input logic cl, output bit acc);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = cl;
    @(negedge clk);
    acc = iv && in_ready && !fl && rst;
    @(posedge clk);
    #1;
    if (acc) sb.push_back(d);
  endtask

  initial begin
    bit            acc;
    bit            pend;
    logic [DW-1:0] pd;
    int            n;

    // Reset
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(FD));
    chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));

    // Streaming 1..5 with out_ready high: each value appears right after its accept
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, DW'(i), 1'b1, 1'b0, 1'b0, acc);
      chk("stream_accept", 64'(acc), 64'(1));
      chk("stream_data", 64'(out_data), 64'(i));
      chk("stream_occ", 64'(occupancy), 64'(1));
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    chk("stream_stall", 64'(stall_cnt), 64'(0));

    // Backpressure: A, B fill the stage, C is held upstream
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1, acc);
    drive(1'b1, DW'('hA), 1'b0, 1'b0, 1'b0, acc);
    drive(1'b1, DW'('hB), 1'b0, 1'b0, 1'b0, acc);
    chk("bp_occ_full", 64'(occupancy), 64'(2));
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    drive(1'b1, DW'('hC), 1'b0, 1'b0, 1'b0, acc);
    chk("bp_c_refused", 64'(acc), 64'(0));
    drive(1'b1, DW'('hC), 1'b0, 1'b0, 1'b0, acc);
    chk("bp_stall3", 64'(stall_cnt), 64'(3));
    acc = 1'b0;
    n = 0;
    while (!acc && n < 10) begin
      drive(1'b1, DW'('hC), 1'b1, 1'b0, 1'b0, acc);
      n++;
    end
    chk("bp_c_accepted", 64'(acc), 64'(1));
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    chk("bp_drained", 64'(sb.size()), 64'(0));
    chk("bp_stall_final", 64'(stall_cnt), 64'(3));

    // Flush while FULL with 0xD offered
    drive(1'b1, DW'('h11), 1'b0, 1'b0, 1'b0, acc);
    drive(1'b1, DW'('h12), 1'b0, 1'b0, 1'b0, acc);
    drive(1'b1, DW'('hD), 1'b0, 1'b1, 1'b0, acc);
    chk("fl_occ", 64'(occupancy), 64'(0));
    chk("fl_out_valid", 64'(out_valid), 64'(0));
    chk("fl_out_data", 64'(out_data), 64'(FD));
    chk("fl_in_ready", 64'(in_ready), 64'(1));
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    chk("fl_no_d", 64'(out_valid), 64'(0));

    // Stall counter saturation, then clear during a stall
    drive(1'b1, DW'('h21), 1'b0, 1'b0, 1'b0, acc);
    repeat (20) drive(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
    chk("sat_15", 64'(stall_cnt), 64'(SAT));
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    chk("sat_clr", 64'(stall_cnt), 64'(0));
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

    // Randomised traffic with source hold rule respected
    pend = 1'b0;
    pd   = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        pend = ($urandom_range(0, 3) != 0);
        pd   = rand_data();
      end
      drive(pend, pend ? pd : rand_data(), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0), acc);
      if (acc || flush) pend = 1'b0;
    end
    flush = 1'b0;
    cnt_clr = 1'b0;
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    chk("rand_drained", 64'(sb.size()), 64'(0));

    // Asynchronous reset between edges while FULL
    drive(1'b1, DW'('h31), 1'b0, 1'b0, 1'b0, acc);
    drive(1'b1, DW'('h32), 1'b0, 1'b0, 1'b0, acc);
    chk("ar_full", 64'(occupancy), 64'(2));
    #2 rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("ar_occ", 64'(occupancy), 64'(0));
    chk("ar_in_ready", 64'(in_ready), 64'(1));
    chk("ar_out_valid", 64'(out_valid), 64'(0));
    chk("ar_out_data", 64'(out_data), 64'(FD));
    chk("ar_stall", 64'(stall_cnt), 64'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1'b1, DW'('h41), 1'b1, 1'b0, 1'b0, acc);
    chk("ar_restart", 64'(out_data), 64'('h41));
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    chk("final_drained", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed-width, enable-only pipeline latch.
- A single-clock elastic pipeline stage carrying a DATA_W-bit payload: the concatenation of instr, pc and decode bits for IF/ID, or any later stage's bundle.
- Adds valid/ready backpressure, a 2-entry skid buffer so in_ready is driven from a register, synchronous flush with bubble-value injection, and a saturating stall counter for perf debug.

Parameters:
- DATA_W, 43, payload width in bits (16 instr + 16 pc + 1 taken + 10 decode).
- FLUSH_DATA, 0, value loaded into both data registers on reset and on flush; this is the NOP/bubble encoding.
- STALL_W, 16, width of the stall cycle counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- flush  input  1  synchronous squash of all held entries (branch mispredict, halt).
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  stage can accept; a registered output.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_W  head payload; equals the main register.
- occupancy  output  2  held entries, 0..2.
- cnt_clr  input  1  synchronous clear of stall_cnt.
- stall_cnt  output  STALL_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Handshake definitions:
  - Accept = in_valid & in_ready.
  - Issue = out_valid & out_ready.
  - Payload must be held by the source while its valid=1 and ready=0.
- Reset (rst=0, async) values:
  - state EMPTY, in_ready=1, out_valid=0, occupancy=0, stall_cnt=0.
  - main and skid registers = FLUSH_DATA, so out_data=FLUSH_DATA.
- States: EMPTY (occ 0), ONE (main valid, occ 1), FULL (main and skid valid, occ 2).
- Transitions (no flush):
  - EMPTY, accept -> ONE; main<=in_data.
  - ONE, accept and issue -> ONE; main<=in_data.
  - ONE, accept and no issue -> FULL; skid<=in_data.
  - ONE, issue and no accept -> EMPTY.
  - FULL, issue -> ONE; main<=skid. No accept is possible because in_ready=0.
  - Any state with no event -> hold; data registers unchanged.
- Outputs:
  - in_ready is registered and equals 1 exactly when the next state is not FULL.
  - out_valid=1 in ONE and FULL.
- Latency: 1 cycle from accept to out_valid in EMPTY; throughput 1 per cycle while out_ready=1.
- Ordering: strict FIFO; no payload is duplicated or lost unless a flush occurs.
- Flush (synchronous, highest priority):
  - next state EMPTY, main and skid <= FLUSH_DATA, next in_ready=1.
  - An accept in the flush cycle is discarded.
  - An issue in the flush cycle still completes; downstream keeps the value it sampled.
- Flush and reset mid-transfer: state is lost; no partial update survives.
- Stall counter:
  - Increments when out_valid & !out_ready.
  - Saturates at all ones.
  - cnt_clr has priority over increment; result is 0 that cycle.
  - flush does not clear the counter.
- Width: all data paths are exactly DATA_W; no truncation or extension.

Decomposition:
- Package pipe_pkg holds:
  - state encoding: EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
  - default DATA_W and FLUSH_DATA (NOP encoding) constants shared by all pipeline stages.
- One sub-module: sat_counter (parameter W; ports clk, rst, clr, inc, cnt), instantiated for stall_cnt.
- Data and state registers live in the top module.

Test Plan:
- Reset with rst=0 for 2 cycles, release -> in_ready=1, out_valid=0, occupancy=0, out_data=FLUSH_DATA, stall_cnt=0.
- Streaming: in_valid=1 with data 0x0001..0x0005, out_ready=1 every cycle -> out_data 1..5 on consecutive cycles, one cycle after each accept; occupancy stays 1; stall_cnt=0.
- Backpressure: accept 0xA, then 0xB with out_ready=0 -> occupancy=2, in_ready=0 on the next cycle, 0xC held upstream. Raise out_ready -> outputs 0xA, 0xB, 0xC in order, none dropped; stall_cnt equals the number of cycles out_ready was low with out_valid=1.
- Flush in FULL with in_valid=1 (0xD) -> next cycle occupancy=0, out_valid=0, out_data=FLUSH_DATA, 0xD not delivered, in_ready=1.
- Counter saturation: STALL_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15. Pulse cnt_clr together with a stall -> stall_cnt=0.
- Async reset mid-stream: drop rst between clock edges while FULL -> outputs return to reset values immediately, before the next edge.
